// File: rtl/img_frame_loader_if.sv
// Beat-stream interface feeding img_frame_loader.
// master drives valid/data/sof/dest and samples ready; slave is the loader side.
interface img_frame_loader_if #(
  parameter int unsigned BEAT_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_sof;
  logic [2:0]        in_dest;

  modport master (
    output in_valid,
    output in_data,
    output in_sof,
    output in_dest,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sof,
    input  in_dest,
    output in_ready
  );
endinterface

// File: rtl/img_frame_loader.sv
// Assembles BEATS beats of BEAT_W bits into one image word (first beat in the MSBs) and
// commits it atomically to one of five per-junction image registers.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_if (slave)   - beat stream: in_valid/in_ready handshake, in_data, in_sof, in_dest
//   img_mid..img_d  - committed images for the Mid, L, R, T, D junctions
//   load_strobe     - one-cycle pulse, bit k marks a new image on destination k
//   frame_err       - one-cycle pulse on a protocol error
//   busy            - state is not idle
//   frames_done     - count of committed images, wraps at 256
module img_frame_loader #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 32,
  parameter int unsigned N_DEST = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  img_frame_loader_if.slave        in_if,
  output logic [BEAT_W*BEATS-1:0]  img_mid,
  output logic [BEAT_W*BEATS-1:0]  img_l,
  output logic [BEAT_W*BEATS-1:0]  img_r,
  output logic [BEAT_W*BEATS-1:0]  img_t,
  output logic [BEAT_W*BEATS-1:0]  img_d,
  output logic [N_DEST-1:0]        load_strobe,
  output logic                     frame_err,
  output logic                     busy,
  output logic [7:0]               frames_done
);

  localparam int unsigned ImgW = BEAT_W * BEATS;
  localparam int unsigned CntW = $clog2(BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);
  localparam logic [2:0]      MaxDest  = 3'(N_DEST - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDiscard, StCommit} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2:0]         dest_q, dest_d;
  logic [ImgW-1:0]    buf_q, buf_d;
  logic [ImgW-1:0]    img_q [N_DEST];
  logic [ImgW-1:0]    img_n [N_DEST];
  logic [N_DEST-1:0]  strobe_q, strobe_d;
  logic               err_q, err_d;
  logic [7:0]         done_q, done_d;

  logic               accept;
  logic               wr_en;
  logic [CntW-1:0]    wr_slot;

  assign in_if.in_ready = (state_q != StCommit);
  assign accept         = in_if.in_valid & in_if.in_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dest_d   = dest_q;
    buf_d    = buf_q;
    img_n    = img_q;
    strobe_d = '0;
    err_d    = 1'b0;
    done_d   = done_q;
    wr_en    = 1'b0;
    wr_slot  = '0;

    unique case (state_q)
      StIdle, StCollect, StDiscard: begin
        if (accept) begin
          if (in_if.in_sof) begin
            // A sof mid-frame abandons the partial frame, then restarts like idle.
            if (state_q == StCollect) err_d = 1'b1;
            if (in_if.in_dest <= MaxDest) begin
              dest_d  = in_if.in_dest;
              wr_en   = 1'b1;
              count_d = CntW'(1);
              state_d = StCollect;
            end else begin
              err_d   = 1'b1;
              state_d = StDiscard;
            end
          end else if (state_q == StCollect) begin
            wr_en   = 1'b1;
            wr_slot = count_q;
            count_d = count_q + 1'b1;
            if (count_q == LastBeat) state_d = StCommit;
          end else if (state_q == StIdle) begin
            err_d = 1'b1;
          end
        end
      end
      StCommit: begin
        for (int k = 0; k < int'(N_DEST); k++) begin
          if (dest_q == 3'(k)) begin
            img_n[k]    = buf_q;
            strobe_d[k] = 1'b1;
          end
        end
        done_d  = done_q + 8'd1;
        count_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Beat i lands in the i-th 32-bit slot counted from the MSB end.
    if (wr_en) buf_d[BEAT_W*int'(LastBeat - wr_slot) +: BEAT_W] = in_if.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      dest_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
      for (int k = 0; k < int'(N_DEST); k++) img_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      done_q   <= done_d;
      img_q    <= img_n;
    end
  end

  // Stale buffer contents are always fully overwritten before a commit, so no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign img_mid     = img_q[0];
  assign img_l       = img_q[1];
  assign img_r       = img_q[2];
  assign img_t       = img_q[3];
  assign img_d       = img_q[4];
  assign load_strobe = strobe_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != StIdle);
  assign frames_done = done_q;

endmodule

// File: tb/tb_img_frame_loader.sv
// Self-checking bench for img_frame_loader: table of single frames plus directed
// sequences for back-to-back, mid-frame sof, bad destination, mid-frame reset and wrap.
module tb_img_frame_loader;
  localparam int W = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_frame_loader_if bus ();

  logic [W-1:0] img_mid, img_l, img_r, img_t, img_d;
  logic [4:0]   load_strobe;
  logic         frame_err, busy;
  logic [7:0]   frames_done;

  img_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus),
    .img_mid     (img_mid),
    .img_l       (img_l),
    .img_r       (img_r),
    .img_t       (img_t),
    .img_d       (img_d),
    .load_strobe (load_strobe),
    .frame_err   (frame_err),
    .busy        (busy),
    .frames_done (frames_done)
  );

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] base;
    logic [31:0] step;
    logic [4:0]  exp_strobe;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t         vecs [5];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           err_cnt = 0;
  int           strobe_cnt = 0;
  int           both_cnt = 0;
  int           rdy_low = 0;
  int           strobe_cyc;
  logic [W-1:0] exp_img [5];
  logic [7:0]   exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (load_strobe != 5'd0) strobe_cnt <= strobe_cnt + 1;
    if (frame_err && load_strobe != 5'd0) both_cnt <= both_cnt + 1;
    if (!bus.in_ready) rdy_low <= rdy_low + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int i = 0; i < 32; i++) begin
        if (act[W-1-32*i -: 32] !== exp[W-1-32*i -: 32]) begin
          $display("FAIL %s word %0d: got %h expected %h", name, i,
                   act[W-1-32*i -: 32], exp[W-1-32*i -: 32]);
          break;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] build(input logic [31:0] base, input logic [31:0] step);
    logic [W-1:0] img;
    img = '0;
    for (int i = 0; i < 32; i++) img[W-1-32*i -: 32] = base + step * 32'(i);
    return img;
  endfunction

  task automatic check_all();
    check_img("img_mid", img_mid, exp_img[0]);
    check_img("img_l",   img_l,   exp_img[1]);
    check_img("img_r",   img_r,   exp_img[2]);
    check_img("img_t",   img_t,   exp_img[3]);
    check_img("img_d",   img_d,   exp_img[4]);
    check("frames_done", 32'(frames_done), 32'(exp_done));
  endtask

  task automatic commit(input int dest, input logic [W-1:0] img);
    exp_img[dest] = img;
    exp_done      = exp_done + 8'd1;
  endtask

  // Returns at a negedge where ready is high; the beat is accepted at the next posedge.
  task automatic send_beat(input logic [31:0] data, input logic sof, input logic [2:0] dest,
                           input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sof   = sof;
    bus.in_dest  = dest;
    n = 0;
    while (!bus.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic send_frame(input logic [2:0] dest, input logic [31:0] base,
                            input logic [31:0] step, input int maxgap);
    for (int i = 0; i < 32; i++) begin
      send_beat(base + step * 32'(i), (i == 0), dest,
                (maxgap > 0 && i > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  // Called right after the last beat: COMMIT cycle, then one strobe cycle, then quiet.
  task automatic finish_frame(input logic [4:0] exp_strobe);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("commit_strobe", 32'(load_strobe), 32'd0);
    check("commit_ready", 32'(bus.in_ready), 32'd0);
    check("commit_busy", 32'(busy), 32'd1);
    @(negedge clk);
    strobe_cyc = cyc;
    check("load_strobe", 32'(load_strobe), 32'(exp_strobe));
    check("strobe_err", 32'(frame_err), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("strobe_one_cycle", 32'(load_strobe), 32'd0);
  endtask

  initial begin
    int e0, s0, r0, t0;
    logic [W-1:0] img;

    vecs[0] = '{3'd0, 32'h0000_0000, 32'h0000_0001, 5'b00001, 32'h0000_0000, 32'h0000_001F};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 5'b00010, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{3'd4, 32'hA5A5_A5A5, 32'h0000_0000, 5'b10000, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[3] = '{3'd2, 32'h1000_0000, 32'h0000_0100, 5'b00100, 32'h1000_0000, 32'h1000_1F00};
    vecs[4] = '{3'd3, 32'hDEAD_0000, 32'h0000_0011, 5'b01000, 32'hDEAD_0000, 32'hDEAD_020F};

    for (int k = 0; k < 5; k++) exp_img[k] = '0;
    exp_done     = 8'd0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;
    bus.in_dest  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_strobe", 32'(load_strobe), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check_all();
    rst = 1'b0;

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].dest, vecs[v].base, vecs[v].step, 0);
      finish_frame(vecs[v].exp_strobe);
      commit(int'(vecs[v].dest), build(vecs[v].base, vecs[v].step));
      case (vecs[v].dest)
        3'd0:    img = img_mid;
        3'd1:    img = img_l;
        3'd2:    img = img_r;
        3'd3:    img = img_t;
        default: img = img_d;
      endcase
      check("vec_hi", img[W-1 -: 32], vecs[v].exp_hi);
      check("vec_lo", img[31:0], vecs[v].exp_lo);
      check_all();
    end

    // Back-to-back frames with valid held high: 66 cycles, ready low once per frame
    #1;
    r0 = rdy_low;
    s0 = strobe_cnt;
    for (int i = 0; i < 32; i++) begin
      send_beat(32'h0F0F_0F0F, (i == 0), 3'd1, 0);
      if (i == 0) t0 = cyc;
    end
    send_frame(3'd4, 32'h5A5A_5A5A, 32'h0000_0000, 0);
    finish_frame(5'b10000);
    commit(1, build(32'h0F0F_0F0F, 32'h0));
    commit(4, build(32'h5A5A_5A5A, 32'h0));
    #1;
    check("b2b_ready_low", 32'(rdy_low - r0), 32'd2);
    check("b2b_cycles", 32'(strobe_cyc - t0), 32'd66);
    check("b2b_strobes", 32'(strobe_cnt - s0), 32'd2);
    check_all();

    // sof at beat 10 of a dest-2 frame restarts a full dest-3 frame
    e0 = err_cnt;
    s0 = strobe_cnt;
    send_frame(3'd2, 32'h2222_0000, 32'h1, 0);
    for (int i = 0; i < 10; i++) send_beat(32'h2200_0000 + 32'(i), (i == 0), 3'd2, 0);
    send_frame(3'd3, 32'h3300_0000, 32'h0000_0101, 0);
    finish_frame(5'b01000);
    // The first dest-2 frame above completed before the abandoned one began.
    #1;
    check("restart_strobes", 32'(strobe_cnt - s0), 32'd2);
    check("restart_err", 32'(err_cnt - e0), 32'd1);
    commit(2, build(32'h2222_0000, 32'h1));
    commit(3, build(32'h3300_0000, 32'h0000_0101));
    check_all();

    // Bad destination: whole frame discarded, then a good dest-0 frame
    e0 = err_cnt;
    s0 = strobe_cnt;
    send_beat(32'hBAD0_0000, 1'b1, 3'd6, 0);
    for (int i = 1; i < 32; i++) send_beat(32'hBAD0_0000 + 32'(i), 1'b0, 3'd0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("discard_busy", 32'(busy), 32'd1);
    send_frame(3'd0, 32'h0C0C_0000, 32'h0000_0007, 0);
    finish_frame(5'b00001);
    commit(0, build(32'h0C0C_0000, 32'h0000_0007));
    #1;
    check("bad_dest_err", 32'(err_cnt - e0), 32'd1);
    check("bad_dest_strobes", 32'(strobe_cnt - s0), 32'd1);
    check_all();

    // Non-sof beat in idle is dropped with an error
    e0 = err_cnt;
    send_beat(32'h1234_5678, 1'b0, 3'd0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("idle_nonsof_err", 32'(err_cnt - e0), 32'd1);
    check("idle_nonsof_busy", 32'(busy), 32'd0);
    check_all();

    // Reset at beat 20, then a clean dest-0 frame
    for (int i = 0; i < 20; i++) send_beat(32'hEEEE_0000 + 32'(i), (i == 0), 3'd0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) exp_img[k] = '0;
    exp_done = 8'd0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_strobe", 32'(load_strobe), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    check_all();
    send_frame(3'd0, 32'h7700_0000, 32'h0000_0003, 0);
    finish_frame(5'b00001);
    commit(0, build(32'h7700_0000, 32'h0000_0003));
    check_all();

    // 255 more frames with random valid gaps: frames_done wraps to 0
    for (int f = 0; f < 255; f++) begin
      logic [31:0] b;
      logic [2:0]  d;
      b = $urandom;
      d = 3'(f % 5);
      send_frame(d, b, 32'h0102_0304, 3);
      finish_frame(5'(1 << d));
      commit(int'(d), build(b, 32'h0102_0304));
      check_all();
    end
    check("wrap_zero", 32'(frames_done), 32'd0);
    #1;
    check("err_strobe_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
